// File: rtl/mem_arbiter_2c.sv
// mem_arbiter_2c
// Shares one byte-wide main-memory port between two cache controllers
// (requester 0 = data cache, requester 1 = instruction cache).
//
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   cN_addr/rd/wr/wdata - requester N memory request (N = 0, 1)
//   cN_lock             - requester N keeps the grant after its request drops
//   cN_rdata/ready      - memory response routed to requester N (0 when not owner)
//   addr_mem, rd_mem, wr_mem, wdata_mem - memory-side request
//   rdata_mem, ready_mem                - memory-side response
//   grant               - one-hot owner (bit0 = c0, bit1 = c1, 00 = none)
//   err_proto           - sticky: owner drove rd and wr together
//   err_timeout         - sticky: watchdog forced a grant release
//
// Arbitration happens in IDLE and TURN; the owner gets a combinational
// pass-through of its request. Every release goes through TURN for one idle
// cycle so the memory bus turns around cleanly. A ready_mem/rdata_mem change
// only reaches the cache-side outputs, never the memory-side ones.
module mem_arbiter_2c #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] c0_addr,
    input  logic          c0_rd,
    input  logic          c0_wr,
    input  logic [DW-1:0] c0_wdata,
    input  logic          c0_lock,
    output logic [DW-1:0] c0_rdata,
    output logic          c0_ready,
    input  logic [AW-1:0] c1_addr,
    input  logic          c1_rd,
    input  logic          c1_wr,
    input  logic [DW-1:0] c1_wdata,
    input  logic          c1_lock,
    output logic [DW-1:0] c1_rdata,
    output logic          c1_ready,
    output logic [AW-1:0] addr_mem,
    output logic          rd_mem,
    output logic          wr_mem,
    output logic [DW-1:0] wdata_mem,
    input  logic [DW-1:0] rdata_mem,
    input  logic          ready_mem,
    output logic [1:0]    grant,
    output logic          err_proto,
    output logic          err_timeout
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          last_owner_reg, last_owner_next;
    logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          err_proto_reg, err_proto_next;
    logic          err_timeout_reg, err_timeout_next;

    // Requester signals gathered into indexable vectors
    logic [1:0]    rd_vec, wr_vec, lock_vec, req_vec, own_vec, ready_vec;
    logic [AW-1:0] addr_arr  [2];
    logic [DW-1:0] wdata_arr [2];
    logic [DW-1:0] rdata_arr [2];
    logic          sel;     // index of current owner (valid only when owned)
    logic          owned;

    assign rd_vec       = {c1_rd, c0_rd};
    assign wr_vec       = {c1_wr, c0_wr};
    assign lock_vec     = {c1_lock, c0_lock};
    assign addr_arr[0]  = c0_addr;
    assign addr_arr[1]  = c1_addr;
    assign wdata_arr[0] = c0_wdata;
    assign wdata_arr[1] = c1_wdata;

    assign own_vec = {state_reg == S_OWN1, state_reg == S_OWN0};
    assign owned   = |own_vec;
    assign sel     = (state_reg == S_OWN1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_vec[gi]   = rd_vec[gi] | wr_vec[gi];
            assign ready_vec[gi] = own_vec[gi] & ready_mem;
            assign rdata_arr[gi] = own_vec[gi] ? rdata_mem : '0;
        end
    endgenerate

    assign c0_ready = ready_vec[0];
    assign c1_ready = ready_vec[1];
    assign c0_rdata = rdata_arr[0];
    assign c1_rdata = rdata_arr[1];

    // Memory side: owner pass-through; rd+wr together is illegal and is
    // suppressed so memory never sees an ambiguous command.
    assign addr_mem  = owned ? addr_arr[sel]  : '0;
    assign wdata_mem = owned ? wdata_arr[sel] : '0;
    assign rd_mem    = owned & rd_vec[sel] & ~wr_vec[sel];
    assign wr_mem    = owned & wr_vec[sel] & ~rd_vec[sel];

    assign grant       = own_vec;
    assign err_proto   = err_proto_reg;
    assign err_timeout = err_timeout_reg;

    always_comb begin
        state_next       = state_reg;
        last_owner_next  = last_owner_reg;
        hold_cnt_next    = hold_cnt_reg;
        err_proto_next   = err_proto_reg;
        err_timeout_next = err_timeout_reg;
        case (state_reg)
            S_IDLE, S_TURN: begin
                hold_cnt_next = '0;
                if (req_vec[0] && req_vec[1]) begin
                    // Tie: the requester that did not own last time wins
                    state_next = last_owner_reg ? S_OWN0 : S_OWN1;
                end else if (req_vec[0]) begin
                    state_next = S_OWN0;
                end else if (req_vec[1]) begin
                    state_next = S_OWN1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_OWN0, S_OWN1: begin
                if (rd_vec[sel] && wr_vec[sel]) begin
                    err_proto_next = 1'b1;
                end
                if (!(req_vec[sel] || lock_vec[sel])) begin
                    state_next      = S_TURN;
                    last_owner_next = sel;
                    hold_cnt_next   = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    // Watchdog: owner loses the port and the next tie
                    state_next       = S_TURN;
                    last_owner_next  = sel;
                    hold_cnt_next    = '0;
                    err_timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next    = S_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            last_owner_reg  <= 1'b1;    // c0 wins the first tie
            hold_cnt_reg    <= '0;
            err_proto_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_owner_reg  <= last_owner_next;
            hold_cnt_reg    <= hold_cnt_next;
            err_proto_reg   <= err_proto_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2c.sv
module tb_mem_arbiter_2c;

    localparam logic [2:0] N  = 3'b000;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] L  = 3'b001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] c0_addr = '0, c1_addr = '0;
    logic        c0_rd = 0, c0_wr = 0, c0_lock = 0;
    logic        c1_rd = 0, c1_wr = 0, c1_lock = 0;
    logic [7:0]  c0_wdata = '0, c1_wdata = '0;
    logic [7:0]  c0_rdata, c1_rdata;
    logic        c0_ready, c1_ready;
    logic [15:0] addr_mem;
    logic        rd_mem, wr_mem;
    logic [7:0]  wdata_mem;
    logic [7:0]  rdata_mem = '0;
    logic        ready_mem = 1'b0;
    logic [1:0]  grant;
    logic        err_proto, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter_2c #(.AW(16), .DW(8), .MAX_HOLD(8)) dut (
        .clock(clock), .reset(reset),
        .c0_addr(c0_addr), .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_wdata(c0_wdata),
        .c0_lock(c0_lock), .c0_rdata(c0_rdata), .c0_ready(c0_ready),
        .c1_addr(c1_addr), .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_wdata(c1_wdata),
        .c1_lock(c1_lock), .c1_rdata(c1_rdata), .c1_ready(c1_ready),
        .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .wdata_mem(wdata_mem), .rdata_mem(rdata_mem), .ready_mem(ready_mem),
        .grant(grant), .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  c0f;       // {rd, wr, lock}
        logic [15:0] c0a;
        logic [2:0]  c1f;
        logic [15:0] c1a;
        logic [7:0]  rdata;
        logic        ready;
        logic [1:0]  e_grant;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_addr;
        logic        e_errp;
        logic        e_errt;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t exp_q[$];

    function automatic vec_t v(input string nm, input logic [2:0] c0f, input logic [15:0] c0a,
                               input logic [2:0] c1f, input logic [15:0] c1a,
                               input logic [7:0] rdata, input logic ready,
                               input logic [1:0] eg, input logic erd, input logic ewr,
                               input logic [15:0] eaddr, input logic eerrp, input logic eerrt);
        vec_t r;
        r.name = nm; r.c0f = c0f; r.c0a = c0a; r.c1f = c1f; r.c1a = c1a;
        r.rdata = rdata; r.ready = ready; r.e_grant = eg; r.e_rd = erd; r.e_wr = ewr;
        r.e_addr = eaddr; r.e_errp = eerrp; r.e_errt = eerrt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare
    task automatic apply(input vec_t r);
        vec_t e;
        logic [7:0] w0, w1, e_wdata;
        @(negedge clock);
        w0 = r.c0a[7:0] ^ 8'h5A;
        w1 = r.c1a[7:0] ^ 8'hA5;
        {c0_rd, c0_wr, c0_lock} = r.c0f;
        {c1_rd, c1_wr, c1_lock} = r.c1f;
        c0_addr = r.c0a; c1_addr = r.c1a;
        c0_wdata = w0;   c1_wdata = w1;
        rdata_mem = r.rdata; ready_mem = r.ready;
        exp_q.push_back(r);
        #1;
        e = exp_q.pop_front();
        e_wdata = (e.e_grant == 2'b01) ? w0 : (e.e_grant == 2'b10) ? w1 : 8'h00;
        chk({e.name, ".grant"}, 32'(grant), 32'(e.e_grant));
        chk({e.name, ".rd_mem"}, 32'(rd_mem), 32'(e.e_rd));
        chk({e.name, ".wr_mem"}, 32'(wr_mem), 32'(e.e_wr));
        chk({e.name, ".addr_mem"}, 32'(addr_mem), 32'(e.e_addr));
        chk({e.name, ".wdata_mem"}, 32'(wdata_mem), 32'(e_wdata));
        chk({e.name, ".c0_ready"}, 32'(c0_ready), 32'((e.e_grant == 2'b01) ? e.ready : 1'b0));
        chk({e.name, ".c0_rdata"}, 32'(c0_rdata), 32'((e.e_grant == 2'b01) ? e.rdata : 8'h00));
        chk({e.name, ".c1_ready"}, 32'(c1_ready), 32'((e.e_grant == 2'b10) ? e.ready : 1'b0));
        chk({e.name, ".c1_rdata"}, 32'(c1_rdata), 32'((e.e_grant == 2'b10) ? e.rdata : 8'h00));
        chk({e.name, ".err_proto"}, 32'(err_proto), 32'(e.e_errp));
        chk({e.name, ".err_timeout"}, 32'(err_timeout), 32'(e.e_errt));
    endtask

    initial begin
        logic found;

        // ---------------- tie and round robin (fresh reset) ----------------
        tbl_a.push_back(v("tie_idle", R, 16'h1000, R, 16'h2000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("tie_c0",   R, 16'h1000, R, 16'h2000, 8'h5A, 1, 2'b01, 1, 0, 16'h1000, 0, 0));
        tbl_a.push_back(v("c0_rel",   N, 16'h1000, R, 16'h2000, 8'h00, 0, 2'b01, 0, 0, 16'h1000, 0, 0));
        tbl_a.push_back(v("turn0",    N, 16'h1000, R, 16'h2000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("c1_own",   R, 16'h1000, R, 16'h2000, 8'h6B, 1, 2'b10, 1, 0, 16'h2000, 0, 0));
        tbl_a.push_back(v("c1_hold",  R, 16'h1000, R, 16'h2000, 8'h00, 0, 2'b10, 1, 0, 16'h2000, 0, 0));
        tbl_a.push_back(v("c1_rel",   R, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b10, 0, 0, 16'h2000, 0, 0));
        tbl_a.push_back(v("turn1",    R, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("c0_regr",  R, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b01, 1, 0, 16'h1000, 0, 0));
        tbl_a.push_back(v("c0_rel2",  N, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b01, 0, 0, 16'h1000, 0, 0));
        tbl_a.push_back(v("turn2",    N, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("idle2",    N, 16'h1000, N, 16'h2000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        // ---------------- single read ----------------
        tbl_a.push_back(v("rd_req",   R, 16'hC08B, N, 16'h0000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("rd_b11",   R, 16'hC08B, N, 16'h0000, 8'h11, 1, 2'b01, 1, 0, 16'hC08B, 0, 0));
        tbl_a.push_back(v("rd_b22",   R, 16'hC08B, N, 16'h0000, 8'h22, 1, 2'b01, 1, 0, 16'hC08B, 0, 0));
        tbl_a.push_back(v("rd_b33",   R, 16'hC08B, N, 16'h0000, 8'h33, 1, 2'b01, 1, 0, 16'hC08B, 0, 0));
        tbl_a.push_back(v("rd_b44",   R, 16'hC08B, N, 16'h0000, 8'h44, 1, 2'b01, 1, 0, 16'hC08B, 0, 0));
        tbl_a.push_back(v("rd_drop",  N, 16'hC08B, N, 16'h0000, 8'h00, 0, 2'b01, 0, 0, 16'hC08B, 0, 0));
        tbl_a.push_back(v("rd_turn",  N, 16'hC08B, N, 16'h0000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("rd_idle",  N, 16'hC08B, N, 16'h0000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        // ---------------- locked eviction + refill ----------------
        tbl_a.push_back(v("lk_req",   W|L, 16'hC000, N, 16'h3000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_a.push_back(v("lk_wr0",   W|L, 16'hC000, N, 16'h3000, 8'h00, 1, 2'b01, 0, 1, 16'hC000, 0, 0));
        tbl_a.push_back(v("lk_wr1",   W|L, 16'hC001, R, 16'h3000, 8'h00, 1, 2'b01, 0, 1, 16'hC001, 0, 0));
        tbl_a.push_back(v("lk_hold",  L,   16'hC001, R, 16'h3000, 8'h00, 0, 2'b01, 0, 0, 16'hC001, 0, 0));
        tbl_a.push_back(v("lk_rf0",   R|L, 16'hC11A, R, 16'h3000, 8'h9C, 1, 2'b01, 1, 0, 16'hC11A, 0, 0));
        tbl_a.push_back(v("lk_rf1",   R|L, 16'hC11B, R, 16'h3000, 8'h9D, 1, 2'b01, 1, 0, 16'hC11B, 0, 0));
        tbl_a.push_back(v("lk_idle",  L,   16'hC11B, R, 16'h3000, 8'h00, 0, 2'b01, 0, 0, 16'hC11B, 0, 0));
        tbl_a.push_back(v("lk_drop",  N,   16'hC11B, R, 16'h3000, 8'h00, 0, 2'b01, 0, 0, 16'hC11B, 0, 0));
        tbl_a.push_back(v("lk_turn",  N,   16'hC11B, R, 16'h3000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        // ---------------- watchdog: c1 holds for MAX_HOLD=8 cycles ----------------
        for (int k = 0; k < 7; k++)
            tbl_a.push_back(v($sformatf("wd%0d", k), N, 16'h4000, R, 16'h3000, 8'(k + 1), 1,
                              2'b10, 1, 0, 16'h3000, 0, 0));
        tbl_a.push_back(v("wd7",      R, 16'h4000, R, 16'h3000, 8'h00, 1, 2'b10, 1, 0, 16'h3000, 0, 0));
        tbl_a.push_back(v("wd_turn",  R, 16'h4000, R, 16'h3000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 1));
        tbl_a.push_back(v("wd_c0",    R, 16'h4000, R, 16'h3000, 8'h00, 1, 2'b01, 1, 0, 16'h4000, 0, 1));
        // ---------------- protocol error ----------------
        tbl_a.push_back(v("pe_both",  R|W, 16'h4000, R, 16'h3000, 8'h00, 0, 2'b01, 0, 0, 16'h4000, 0, 1));
        tbl_a.push_back(v("pe_drop",  N,   16'h4000, N, 16'h3000, 8'h00, 0, 2'b01, 0, 0, 16'h4000, 1, 1));
        tbl_a.push_back(v("pe_turn",  N,   16'h4000, N, 16'h3000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 1, 1));
        tbl_a.push_back(v("pe_idle",  N,   16'h4000, N, 16'h3000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 1, 1));
        // ---------------- after mid-burst reset: c0 wins the tie ----------------
        tbl_b.push_back(v("rs_tie",   R, 16'h5000, R, 16'h6000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));
        tbl_b.push_back(v("rs_c0",    R, 16'h5000, R, 16'h6000, 8'h00, 1, 2'b01, 1, 0, 16'h5000, 0, 0));
        tbl_b.push_back(v("rs_rel",   N, 16'h5000, N, 16'h6000, 8'h00, 0, 2'b01, 0, 0, 16'h5000, 0, 0));
        tbl_b.push_back(v("rs_turn",  N, 16'h5000, N, 16'h6000, 8'h00, 0, 2'b00, 0, 0, 16'h0000, 0, 0));

        // ---------------- reset state, with requests active ----------------
        #2 reset = 1'b1;
        @(negedge clock);
        c0_rd = 1; c1_wr = 1; c0_addr = 16'hABCD; c1_addr = 16'h1234;
        c0_wdata = 8'h99; rdata_mem = 8'hFF; ready_mem = 1;
        #1;
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.rd_mem", 32'(rd_mem), 32'h0);
        chk("rst.wr_mem", 32'(wr_mem), 32'h0);
        chk("rst.addr_mem", 32'(addr_mem), 32'h0);
        chk("rst.wdata_mem", 32'(wdata_mem), 32'h0);
        chk("rst.c0_ready", 32'(c0_ready), 32'h0);
        chk("rst.c0_rdata", 32'(c0_rdata), 32'h0);
        chk("rst.c1_ready", 32'(c1_ready), 32'h0);
        chk("rst.errs", 32'({err_proto, err_timeout}), 32'h0);
        @(negedge clock);
        c0_rd = 0; c1_wr = 0; rdata_mem = 0; ready_mem = 0;
        reset = 1'b0;

        foreach (tbl_a[i]) apply(tbl_a[i]);

        // ---------------- reset mid-burst ----------------
        @(negedge clock);
        c0_wr = 1; c0_addr = 16'hC0FF; c0_wdata = 8'h77; ready_mem = 1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #1;
            if (grant == 2'b01 && wr_mem) begin
                found = 1'b1;
                break;
            end
        end
        chk("mb.burst_started", 32'(found), 32'h1);
        chk("mb.errs_before", 32'({err_proto, err_timeout}), 32'h3);
        #1 reset = 1'b1;
        #1;
        chk("mb.grant", 32'(grant), 32'h0);
        chk("mb.wr_mem", 32'(wr_mem), 32'h0);
        chk("mb.addr_mem", 32'(addr_mem), 32'h0);
        chk("mb.c0_ready", 32'(c0_ready), 32'h0);
        chk("mb.err_proto", 32'(err_proto), 32'h0);
        chk("mb.err_timeout", 32'(err_timeout), 32'h0);
        @(negedge clock);
        c0_wr = 0; ready_mem = 0;
        reset = 1'b0;

        foreach (tbl_b[i]) apply(tbl_b[i]);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Absolute time bound so a broken design can never hang the run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
